// File: rtl/i2c_master_rw.sv
// i2c_master_rw: byte-level I2C master executing START/WRITE/READ_ACK/READ_NACK/STOP commands
// Ports: clk/reset (sync, active-high); cmd_valid/cmd_ready/cmd/cmd_wdata command handshake;
//        rsp_valid/rsp_rdata/rsp_nack byte completion; busy when not IDLE; scl/sda open-drain lines.
// Optional I2C_CLK_STRETCH_EN: synchronise scl and stall the quarter counter while a slave holds scl low.
module i2c_master_rw #(
    parameter int SYS_CLK_HZ = 100_000_000,
    parameter int SCL_HZ     = 100_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_nack,
    output logic       busy,
    inout  wire        scl,
    inout  wire        sda
);
    localparam int Q = SYS_CLK_HZ / (4 * SCL_HZ);
    localparam int CW = (Q > 1) ? $clog2(Q) : 1;
    localparam logic [CW-1:0] QL = CW'(Q - 1);
    localparam logic [1:0] OP_W = 2'd0, OP_RA = 2'd1, OP_RN = 2'd2;

    typedef enum logic [4:0] {
        IDLE, START1, START2, HOLD, RS1, RS2,
        BIT0, BIT1, BIT2, BIT3, ACK0, ACK1, ACK2, ACK3,
        STOP1, STOP2, STOP3
    } state_t;

    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic half_q, half_d, ack_q, ack_d, nack_q, nack_d, rv_q, rv_d;
    logic scl_oe_q, scl_oe_d, sda_oe_q, sda_oe_d, busy_q, busy_d, ready_q, ready_d;
    logic [7:0] sr_q, sr_d, rdata_q, rdata_d;
    logic [2:0] idx_q, idx_d;
    logic [1:0] op_q, op_d;
    logic tick, t, two, adv, acc, hold, bit_st, ack_st;

`ifdef I2C_CLK_STRETCH_EN
    logic scl_s1_q, scl_s2_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_s1_q <= 1'b1;
            scl_s2_q <= 1'b1;
        end else begin
            scl_s1_q <= scl;
            scl_s2_q <= scl_s1_q;
        end
    end
    // a released scl still reading low means a slave is stretching the clock
    assign hold = ~scl_oe_q & ~scl_s2_q;
`else
    assign hold = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        idx_d   = idx_q;
        op_d    = op_q;
        ack_d   = ack_q;
        rdata_d = rdata_q;
        nack_d  = nack_q;
        rv_d    = 1'b0;
        acc     = cmd_valid & ready_q;
        tick    = cnt_q == QL;
        t       = tick & ~hold;
        two     = state_q inside {START1, START2, STOP2, STOP3};
        // 2Q phases advance on the second quarter tick
        adv     = t & (~two | half_q);
        half_d  = two & (half_q ^ t);
        cnt_d   = (state_q == IDLE || state_q == HOLD || tick || hold) ? '0 : cnt_q + 1'b1;
        case (state_q)
            IDLE:   state_d = (acc && cmd == 3'd0) ? START1 : IDLE;
            START1: state_d = adv ? START2 : state_q;
            START2: state_d = adv ? HOLD : state_q;
            HOLD: if (acc) begin
                case (cmd)
                    3'd0: state_d = RS1;
                    3'd1, 3'd2, 3'd3: begin
                        state_d = BIT0;
                        idx_d   = 3'd7;
                        op_d    = (cmd == 3'd1) ? OP_W : (cmd == 3'd2) ? OP_RA : OP_RN;
                        sr_d    = (cmd == 3'd1) ? cmd_wdata : 8'h00;
                    end
                    3'd4: state_d = STOP1;
                    default: state_d = HOLD;
                endcase
            end
            RS1:  state_d = adv ? RS2 : state_q;
            RS2:  state_d = adv ? START1 : state_q;
            BIT0: state_d = adv ? BIT1 : state_q;
            BIT1: if (adv) begin
                state_d = BIT2;
                if (op_q != OP_W) sr_d[idx_q] = sda;
            end
            BIT2: state_d = adv ? BIT3 : state_q;
            BIT3: if (adv) begin
                state_d = (idx_q == 3'd0) ? ACK0 : BIT0;
                idx_d   = idx_q - 3'd1;
            end
            ACK0: state_d = adv ? ACK1 : state_q;
            ACK1: if (adv) begin
                state_d = ACK2;
                ack_d   = sda;
            end
            ACK2: state_d = adv ? ACK3 : state_q;
            ACK3: if (adv) begin
                state_d = HOLD;
                rv_d    = 1'b1;
                nack_d  = (op_q == OP_W) & ack_q;
                rdata_d = (op_q == OP_W) ? rdata_q : sr_q;
            end
            STOP1:   state_d = adv ? STOP2 : state_q;
            STOP2:   state_d = adv ? STOP3 : state_q;
            STOP3:   state_d = adv ? IDLE : state_q;
            default: state_d = IDLE;
        endcase
        // line drives are decoded from the next state so they change together with it
        bit_st   = state_d inside {BIT0, BIT1, BIT2, BIT3};
        ack_st   = state_d inside {ACK0, ACK1, ACK2, ACK3};
        scl_oe_d = state_d inside {START2, HOLD, RS1, BIT0, BIT3, ACK0, ACK3, STOP1};
        sda_oe_d = (state_d inside {START1, START2, HOLD, STOP1, STOP2})
                 | (bit_st & op_d == OP_W & ~sr_d[idx_d])
                 | (ack_st & op_d == OP_RA);
        busy_d   = state_d != IDLE;
        ready_d  = state_d inside {IDLE, HOLD};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            half_q   <= 1'b0;
            sr_q     <= 8'h00;
            idx_q    <= 3'd0;
            op_q     <= OP_W;
            ack_q    <= 1'b0;
            rdata_q  <= 8'h00;
            nack_q   <= 1'b0;
            rv_q     <= 1'b0;
            scl_oe_q <= 1'b0;
            sda_oe_q <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            half_q   <= half_d;
            sr_q     <= sr_d;
            idx_q    <= idx_d;
            op_q     <= op_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
            nack_q   <= nack_d;
            rv_q     <= rv_d;
            scl_oe_q <= scl_oe_d;
            sda_oe_q <= sda_oe_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
        end
    end

    assign scl       = scl_oe_q ? 1'b0 : 1'bz;
    assign sda       = sda_oe_q ? 1'b0 : 1'bz;
    assign cmd_ready = ready_q;
    assign rsp_valid = rv_q;
    assign rsp_rdata = rdata_q;
    assign rsp_nack  = nack_q;
    assign busy      = busy_q;
endmodule
